// File: rtl/hamming_read_sched_if.sv
// hamming_read_sched_if: control, memory-read and decoded-output signals of the read scheduler
interface hamming_read_sched_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_words;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:1]        mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [4:1]        out_data;
  logic              out_error;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_count;
  logic              clr_err;
  modport master (
    input  start, base_addr, num_words, mem_rd_data, out_ready, clr_err,
    output mem_rd_en, mem_addr, out_valid, out_data, out_error, out_addr, busy, done, err_count
  );
  modport slave (
    output start, base_addr, num_words, mem_rd_data, out_ready, clr_err,
    input  mem_rd_en, mem_addr, out_valid, out_data, out_error, out_addr, busy, done, err_count
  );
endinterface

// File: rtl/hamming_read_sched.sv
// hamming_read_sched: sweeps a memory range, Hamming(7,4)-decodes each word and streams it out
module hamming_code_decoder (
  input  logic [7:1] code_in,
  output logic [4:1] data_out,
  output logic       error
);
  logic [7:1] h, flip, fix;
  logic [2:0] syn;
  // code_in[7] is Hamming position 1; syndrome names the flipped position, which is corrected
  always_comb begin
    h = {code_in[1], code_in[2], code_in[3], code_in[4], code_in[5], code_in[6], code_in[7]};
    syn = {h[4] ^ h[5] ^ h[6] ^ h[7], h[2] ^ h[3] ^ h[6] ^ h[7], h[1] ^ h[3] ^ h[5] ^ h[7]};
    flip = (syn == 3'd0) ? 7'd0 : 7'(7'd1 << (syn - 3'd1));
    fix = h ^ flip;
    data_out = {fix[3], fix[5], fix[6], fix[7]};
    error = |syn;
  end
endmodule

module hamming_read_sched #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  hamming_read_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, DONE} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [7:1]        code;
  logic [4:1]        dec_data;
  logic              dec_err;
  logic              hs, last;
  logic [CNT_W-1:0]  err_count;
  hamming_code_decoder u_dec (.code_in(code), .data_out(dec_data), .error(dec_err));
  assign hs   = (state == OUT) && bus.out_ready;
  assign last = remaining == (ADDR_W + 1)'(1);
  assign bus.mem_rd_en = state == READ;
  assign bus.mem_addr  = addr;
  assign bus.out_valid = state == OUT;
  assign bus.out_data  = dec_data;
  assign bus.out_error = dec_err;
  assign bus.out_addr  = addr;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
  assign bus.err_count = err_count;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state: one read, one capture cycle, then hold the word until accepted
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = !bus.start ? IDLE : (bus.num_words == '0) ? DONE : READ;
      READ: state_n = WAIT;
      WAIT: state_n = OUT;
      OUT:  state_n = !hs ? OUT : last ? DONE : READ;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // sweep bookkeeping and codeword capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      remaining <= '0;
      code <= '0;
    end else begin
      if (state == IDLE && bus.start && bus.num_words != '0) begin
        addr <= bus.base_addr;
        remaining <= bus.num_words;
      end
      if (state == WAIT) code <= bus.mem_rd_data;
      if (hs) begin
        remaining <= remaining - 1'b1;
        if (!last) addr <= addr + 1'b1;
      end
    end
  // saturating error counter; clear wins over a coincident increment
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else if (bus.clr_err) err_count <= '0;
    else if (hs && dec_err && !(&err_count)) err_count <= err_count + 1'b1;
endmodule

// File: tb/tb_hamming_read_sched.sv
// tb_hamming_read_sched: directed checks of the Hamming read scheduler against hand-computed values
module tb_hamming_read_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int snap;
  logic [7:1] mem [256];
  logic [7:0] rd_q [$];
  hamming_read_sched_if #(.ADDR_W(8), .CNT_W(16)) bus ();
  hamming_read_sched #(.ADDR_W(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // memory model with one-cycle read latency plus read/done monitors
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= mem[bus.mem_addr];
      rd_cnt++;
      rd_q.push_back(bus.mem_addr);
    end
    if (bus.done) done_cnt++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [7:0] base, input logic [8:0] num);
    bus.base_addr = base;
    bus.num_words = num;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 7'b0000000;
    mem[8'h10] = 7'b1011010;
    mem[8'h11] = 7'b1101001;
    mem[8'h12] = 7'b0000000;
    mem[8'h20] = 7'b1011011;
    mem[8'h21] = 7'b1011011;
    mem[8'hFF] = 7'b1101001;
    mem[8'h00] = 7'b1011010;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.out_ready = 1'b1;
    bus.clr_err = 1'b0;
    bus.mem_rd_data = '0;
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_rden", bus.mem_rd_en, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_err", bus.out_error, 0);
    chk("rst_oaddr", bus.out_addr, 0);
    chk("rst_cnt", bus.err_count, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    // two clean words at 0x10, 0x11 with minimum spacing
    go(8'h10, 9'd2);
    chk("a_rden0", bus.mem_rd_en, 1);
    chk("a_maddr0", bus.mem_addr, 8'h10);
    chk("a_busy", bus.busy, 1);
    tick();
    chk("a_wait_rden", bus.mem_rd_en, 0);
    chk("a_wait_valid", bus.out_valid, 0);
    tick();
    chk("a_valid0", bus.out_valid, 1);
    chk("a_data0", bus.out_data, 4'b1010);
    chk("a_err0", bus.out_error, 0);
    chk("a_oaddr0", bus.out_addr, 8'h10);
    tick();
    chk("a_rden1", bus.mem_rd_en, 1);
    chk("a_maddr1", bus.mem_addr, 8'h11);
    tick();
    tick();
    chk("a_data1", bus.out_data, 4'b0001);
    chk("a_err1", bus.out_error, 0);
    chk("a_oaddr1", bus.out_addr, 8'h11);
    tick();
    chk("a_done", bus.done, 1);
    chk("a_done_busy", bus.busy, 1);
    tick();
    chk("a_idle_done", bus.done, 0);
    chk("a_idle_busy", bus.busy, 0);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_rd_cnt", rd_cnt, 2);
    chk("a_errcnt", bus.err_count, 0);
    // single-bit-flipped word is corrected and counted
    go(8'h20, 9'd1);
    tick();
    tick();
    chk("b_data", bus.out_data, 4'b1010);
    chk("b_err", bus.out_error, 1);
    tick();
    chk("b_errcnt", bus.err_count, 1);
    tick();
    // backpressure holds the word; start while busy is ignored
    bus.out_ready = 1'b0;
    go(8'h11, 9'd2);
    tick();
    tick();
    snap = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("c_valid", bus.out_valid, 1);
      chk("c_data", bus.out_data, 4'b0001);
      chk("c_oaddr", bus.out_addr, 8'h11);
      chk("c_rden", bus.mem_rd_en, 0);
      if (i == 2) begin
        bus.base_addr = 8'h50;
        bus.num_words = 9'd0;
        bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0;
    end
    chk("c_rd_hold", rd_cnt, snap);
    chk("c_ign_valid", bus.out_valid, 1);
    chk("c_ign_oaddr", bus.out_addr, 8'h11);
    bus.out_ready = 1'b1;
    tick();
    chk("c_next_rden", bus.mem_rd_en, 1);
    chk("c_next_maddr", bus.mem_addr, 8'h12);
    tick();
    tick();
    chk("c_data2", bus.out_data, 4'b0000);
    tick();
    chk("c_done", bus.done, 1);
    tick();
    // address wraps from 0xFF to 0x00
    rd_q.delete();
    snap = done_cnt;
    go(8'hFF, 9'd2);
    chk("d_maddr0", bus.mem_addr, 8'hFF);
    tick();
    tick();
    chk("d_data0", bus.out_data, 4'b0001);
    tick();
    chk("d_maddr1", bus.mem_addr, 8'h00);
    tick();
    tick();
    chk("d_oaddr1", bus.out_addr, 8'h00);
    chk("d_data1", bus.out_data, 4'b1010);
    chk("d_early_done", done_cnt, snap);
    tick();
    chk("d_done", bus.done, 1);
    chk("d_rdq_n", rd_q.size(), 2);
    chk("d_rdq0", rd_q[0], 8'hFF);
    chk("d_rdq1", rd_q[1], 8'h00);
    tick();
    // zero-length sweep: no read, immediate done
    snap = rd_cnt;
    go(8'h40, 9'd0);
    chk("e_done", bus.done, 1);
    chk("e_rden", bus.mem_rd_en, 0);
    tick();
    chk("e_idle", bus.busy, 0);
    chk("e_rd_cnt", rd_cnt, snap);
    // asynchronous reset in OUT aborts without done
    go(8'h20, 9'd2);
    tick();
    tick();
    chk("f_pre_valid", bus.out_valid, 1);
    chk("f_pre_err", bus.out_error, 1);
    snap = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("f_valid", bus.out_valid, 0);
    chk("f_busy", bus.busy, 0);
    chk("f_data", bus.out_data, 0);
    chk("f_err", bus.out_error, 0);
    chk("f_oaddr", bus.out_addr, 0);
    chk("f_maddr", bus.mem_addr, 0);
    chk("f_errcnt", bus.err_count, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("f_no_done", done_cnt, snap);
    go(8'h10, 9'd1);
    chk("f_fresh_maddr", bus.mem_addr, 8'h10);
    tick();
    tick();
    chk("f_fresh_data", bus.out_data, 4'b1010);
    tick();
    chk("f_fresh_done", bus.done, 1);
    tick();
    // clear coinciding with an error handshake wins
    go(8'h20, 9'd1);
    tick();
    tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("g_clr_coinc", bus.err_count, 0);
    tick();
    go(8'h21, 9'd1);
    tick();
    tick();
    tick();
    chk("g_inc", bus.err_count, 1);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hamming_read_sched.md
HAMMING_READ_SCHED -- requirements
Module: hamming_read_sched

Interface
REQ-001 Parameter ADDR_W, default 8, shall set the memory address width.
REQ-002 Parameter CNT_W, default 16, shall set the error-counter width.
REQ-003 clk  in  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  shall be the reset, asynchronous and active-high.
REQ-005 start  in  1  shall be a single-cycle request to begin a sweep.
REQ-006 base_addr  in  ADDR_W  shall be the first word address, sampled on accepted start.
REQ-007 num_words  in  ADDR_W+1  shall be the word count, sampled on accepted start.
REQ-008 mem_rd_en  out  1  shall be the memory read strobe.
REQ-009 mem_addr  out  ADDR_W  shall be the memory read address.
REQ-010 mem_rd_data  in  7  shall be codeword [7:1], valid the cycle after mem_rd_en.
REQ-011 out_valid  out  1  shall flag a decoded word on the output.
REQ-012 out_ready  in  1  shall be downstream acceptance.
REQ-013 out_data  out  4  shall be decoded data [4:1].
REQ-014 out_error  out  1  shall be the decoder error flag for out_data.
REQ-015 out_addr  out  ADDR_W  shall be the address of the word on the output.
REQ-016 busy  out  1  shall be high in every state except IDLE.
REQ-017 done  out  1  shall be a one-cycle pulse at sweep end.
REQ-018 err_count  out  CNT_W  shall be the saturating count of accepted words with out_error=1.
REQ-019 clr_err  in  1  shall synchronously clear err_count.

Function
REQ-020 The block shall instantiate one hamming_code_decoder, driving code_in from an internal 7-bit code register.
REQ-021 FSM states shall be IDLE, READ, WAIT, OUT, DONE.
REQ-022 IDLE: start with num_words!=0 shall latch base_addr into addr and num_words into remaining, then go to READ.
REQ-023 IDLE: start with num_words==0 shall go to DONE without any memory read.
REQ-024 READ: mem_rd_en=1 and mem_addr=addr for exactly one cycle, then WAIT.
REQ-025 WAIT: mem_rd_data shall be captured into the code register, then OUT.
REQ-026 OUT: out_valid=1; out_data, out_error, out_addr shall be held stable until out_valid&out_ready.
REQ-027 On handshake, remaining shall decrement; if remaining was 1 go to DONE, else addr increments and FSM goes to READ.
REQ-028 addr increment shall wrap modulo 2^ADDR_W (address 255 followed by 0 at default width).
REQ-029 Minimum spacing shall be 3 cycles per word (READ, WAIT, OUT with out_ready=1).
REQ-030 DONE: done=1 for one cycle, then IDLE; busy shall remain 1 in DONE.
REQ-031 start while busy=1 shall be ignored, with no effect on addr, remaining or outputs.
REQ-032 On each handshake with out_error=1, err_count shall increment, saturating at 2^CNT_W-1.
REQ-033 clr_err shall force err_count to 0 in any state; if clr_err coincides with an increment, the result shall be 0.
REQ-034 mem_rd_en shall be 0 outside READ, and out_valid shall be 0 outside OUT.

Reset
REQ-035 rst=1 shall immediately force IDLE and clear busy, done, out_valid, mem_rd_en, mem_addr, out_data, out_error, out_addr, err_count, addr, remaining and the code register to 0.
REQ-036 rst asserted mid-sweep shall abort the sweep with no done pulse; the first post-reset start shall behave as a fresh sweep.

Verification
REQ-037 base_addr=0x10, num_words=2, mem[0x10]=1011010, mem[0x11]=1101001, out_ready=1 -> outputs (0x10,1010,err 0), then (0x11,0001,err 0); done once; err_count=0.
REQ-038 mem[0x20]=1011011 (single-bit flip of 1011010), num_words=1 -> out_data=1010, out_error=1, err_count=1.
REQ-039 out_ready held 0 for 5 cycles in OUT -> out_valid and outputs stable all 5 cycles; no new mem_rd_en until handshake.
REQ-040 base_addr=0xFF, num_words=2 -> mem_addr sequence 0xFF then 0x00; done after second handshake.
REQ-041 num_words=0 -> no mem_rd_en; done pulses within 2 cycles; start pulsed mid-sweep -> ignored.
REQ-042 rst pulsed while in OUT -> all outputs 0 asynchronously; no done; err_count=0; clr_err coinciding with an error handshake -> err_count=0.
